// File: rtl/cp0_unit.sv
// MIPS coprocessor-0: BadVAddr/Count/Compare/Status/Cause/EPC with forwarded mfc0 reads,
// exception/ERET recording, registered pipeline flush, interrupt sync and divided timer.
module cp0_unit #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            rd_addr,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [4:0]            wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_in_delay,
  input  logic                  exc_bva_valid,
  input  logic [31:0]           exc_bva,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  int_pending,
  output logic                  timer_int_o,
  output logic                  flush,
  output logic [31:0]           flush_pc
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam int         DIV_W         = 5;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [31:0]           badVAddr_q, badVAddr_d, count_q, count_d, compare_q, compare_d;
  logic [31:0]           epc_q, epc_d, flushPc_q, flushPc_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [7:0]            statusIm_q, statusIm_d;
  logic                  statusExl_q, statusExl_d, statusIe_q, statusIe_d;
  logic                  causeBd_q, causeBd_d, causeTi_q, causeTi_d;
  logic [1:0]            causeSwIp_q, causeSwIp_d;
  logic [4:0]            causeExc_q, causeExc_d;
  logic                  intPending_q, intPending_d, flush_q, flush_d;
  logic [NUM_HW_INT-1:0] sync1_q, sync2_q;

  logic [5:0]  hwIp;
  logic [7:0]  ip;
  logic        wrEn, wrCount, wrCompare, wrStatus, wrCause, wrEpc, divWrap;
  logic [31:0] countInc, statusRd, causeRd, regRd, fwdRd;

  // Unused interrupt lines read as zero; the timer shares IP[7] with the last line.
  always_comb begin
    hwIp = '0;
    hwIp[NUM_HW_INT-1:0] = sync2_q;
  end

  assign ip       = {causeTi_q | hwIp[5], hwIp[4:0], causeSwIp_q};
  assign statusRd = {9'd0, 1'b1, 6'd0, statusIm_q, 6'd0, statusExl_q, statusIe_q};
  assign causeRd  = {causeBd_q, causeTi_q, 14'd0, ip, 1'b0, causeExc_q, 2'b00};

  // An mtc0 colliding with a committed exception is dropped entirely.
  assign wrEn      = we & ~exc_valid;
  assign wrCount   = wrEn && (wr_addr == ADDR_COUNT);
  assign wrCompare = wrEn && (wr_addr == ADDR_COMPARE);
  assign wrStatus  = wrEn && (wr_addr == ADDR_STATUS);
  assign wrCause   = wrEn && (wr_addr == ADDR_CAUSE);
  assign wrEpc     = wrEn && (wr_addr == ADDR_EPC);
  assign divWrap   = (div_q == DIV_LAST);
  assign countInc  = count_q + 32'd1;

  always_comb begin
    case (rd_addr)
      ADDR_BADVADDR: regRd = badVAddr_q;
      ADDR_COUNT:    regRd = count_q;
      ADDR_COMPARE:  regRd = compare_q;
      ADDR_STATUS:   regRd = statusRd;
      ADDR_CAUSE:    regRd = causeRd;
      ADDR_EPC:      regRd = epc_q;
      default:       regRd = 32'd0;
    endcase
  end

  always_comb begin
    case (wr_addr)
      ADDR_BADVADDR: fwdRd = badVAddr_q;
      ADDR_COUNT:    fwdRd = wr_data;
      ADDR_COMPARE:  fwdRd = wr_data;
      ADDR_STATUS:   fwdRd = {9'd0, 1'b1, 6'd0, wr_data[15:8], 6'd0, wr_data[1:0]};
      ADDR_CAUSE:    fwdRd = {causeBd_q, causeTi_q, 14'd0, ip[7:2], wr_data[9:8], 1'b0,
                              causeExc_q, 2'b00};
      ADDR_EPC:      fwdRd = wr_data;
      default:       fwdRd = 32'd0;
    endcase
  end

  assign rd_data = (wrEn && (wr_addr == rd_addr)) ? fwdRd : regRd;

  always_comb begin
    badVAddr_d   = badVAddr_q;
    count_d      = count_q;
    compare_d    = compare_q;
    epc_d        = epc_q;
    flushPc_d    = flushPc_q;
    div_d        = divWrap ? '0 : div_q + DIV_W'(1);
    statusIm_d   = statusIm_q;
    statusExl_d  = statusExl_q;
    statusIe_d   = statusIe_q;
    causeBd_d    = causeBd_q;
    causeTi_d    = causeTi_q;
    causeSwIp_d  = causeSwIp_q;
    causeExc_d   = causeExc_q;
    intPending_d = |(ip & statusIm_q) & statusIe_q & ~statusExl_q;
    flush_d      = 1'b0;

    if (divWrap) count_d = countInc;
    if (wrCount) begin
      count_d = wr_data;
      div_d   = '0;
    end
    // A Compare write always clears TI, even if an increment matches the old value.
    if (wrCompare) begin
      compare_d = wr_data;
      causeTi_d = 1'b0;
    end else if (divWrap && !wrCount && (countInc == compare_q)) begin
      causeTi_d = 1'b1;
    end
    if (wrStatus) begin
      statusIm_d  = wr_data[15:8];
      statusExl_d = wr_data[1];
      statusIe_d  = wr_data[0];
    end
    if (wrCause) causeSwIp_d = wr_data[9:8];
    if (wrEpc)   epc_d = wr_data;

    if (exc_valid) begin
      if (!statusExl_q) begin
        epc_d     = exc_in_delay ? exc_pc - 32'd4 : exc_pc;
        causeBd_d = exc_in_delay;
      end
      statusExl_d = 1'b1;
      causeExc_d  = exc_code;
      if (exc_bva_valid) badVAddr_d = exc_bva;
      flush_d   = 1'b1;
      flushPc_d = EXC_VECTOR;
    end else if (eret) begin
      statusExl_d = 1'b0;
      flush_d     = 1'b1;
      flushPc_d   = wrEpc ? wr_data : epc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badVAddr_q   <= '0;
      count_q      <= '0;
      compare_q    <= '0;
      epc_q        <= '0;
      flushPc_q    <= '0;
      div_q        <= '0;
      statusIm_q   <= '0;
      statusExl_q  <= 1'b0;
      statusIe_q   <= 1'b0;
      causeBd_q    <= 1'b0;
      causeTi_q    <= 1'b0;
      causeSwIp_q  <= '0;
      causeExc_q   <= '0;
      intPending_q <= 1'b0;
      flush_q      <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
    end else begin
      badVAddr_q   <= badVAddr_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      epc_q        <= epc_d;
      flushPc_q    <= flushPc_d;
      div_q        <= div_d;
      statusIm_q   <= statusIm_d;
      statusExl_q  <= statusExl_d;
      statusIe_q   <= statusIe_d;
      causeBd_q    <= causeBd_d;
      causeTi_q    <= causeTi_d;
      causeSwIp_q  <= causeSwIp_d;
      causeExc_q   <= causeExc_d;
      intPending_q <= intPending_d;
      flush_q      <= flush_d;
      sync1_q      <= hw_int;
      sync2_q      <= sync1_q;
    end
  end

  assign int_pending = intPending_q;
  assign timer_int_o = causeTi_q;
  assign flush       = flush_q;
  assign flush_pc    = flushPc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios plus randomized traffic, all checked against a
// word-level model where Count is derived from elapsed ticks rather than a divider.
module tb_cp0_unit;

  localparam int          DIV = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk, rst;
  logic [4:0]  rd_addr, wr_addr, exc_code;
  logic [31:0] rd_data, wr_data, exc_pc, exc_bva, flush_pc;
  logic        we, exc_valid, exc_in_delay, exc_bva_valid, eret;
  logic [5:0]  hw_int;
  logic        int_pending, timer_int_o, flush;

  cp0_unit #(.NUM_HW_INT(6), .COUNT_DIV(DIV), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_in_delay(exc_in_delay), .exc_bva_valid(exc_bva_valid),
    .exc_bva(exc_bva), .eret(eret), .hw_int(hw_int), .int_pending(int_pending),
    .timer_int_o(timer_int_o), .flush(flush), .flush_pc(flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: registers as architectural words, Count as base + elapsed ticks / DIV.
  logic [31:0] mBva, mCountBase, mCompare, mStatus, mCauseSw, mEpc, mFlushPc;
  int unsigned mTicks;
  logic [5:0]  mH1, mH2;
  logic        mIntPend, mFlush;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] mCount();
    return mCountBase + 32'(mTicks / DIV);
  endfunction

  function automatic logic [31:0] mStatusView(input logic [31:0] w);
    return (w & 32'h0000_FF03) | 32'h0040_0000;
  endfunction

  function automatic logic [31:0] mCauseRd();
    logic [7:0] ipv;
    ipv = {mCauseSw[30] | mH2[5], mH2[4:0], mCauseSw[9:8]};
    return (mCauseSw & 32'hC000_007C) | {16'd0, ipv, 8'd0};
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    case (a)
      5'd8:    return mBva;
      5'd9:    return mCount();
      5'd11:   return mCompare;
      5'd12:   return mStatus;
      5'd13:   return mCauseRd();
      5'd14:   return mEpc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mExpectedRd();
    if (we && !exc_valid && wr_addr == rd_addr) begin
      case (wr_addr)
        5'd8:                return mBva;
        5'd9, 5'd11, 5'd14:  return wr_data;
        5'd12:               return mStatusView(wr_data);
        5'd13:               return (mCauseRd() & ~32'h300) | (wr_data & 32'h300);
        default:             return 32'd0;
      endcase
    end
    return mRead(rd_addr);
  endfunction

  function automatic void modelReset();
    mBva = 0; mCountBase = 0; mTicks = 0; mCompare = 0; mStatus = 32'h0040_0000;
    mCauseSw = 0; mEpc = 0; mH1 = 0; mH2 = 0; mIntPend = 0; mFlush = 0; mFlushPc = 0;
  endfunction

  function automatic void modelStep();
    logic [31:0] causeNow;
    logic        pend, oldExl, wrOk;
    if (rst) begin
      modelReset();
      return;
    end
    causeNow = mCauseRd();
    pend     = (|(causeNow[15:8] & mStatus[15:8])) && mStatus[0] && !mStatus[1];
    oldExl   = mStatus[1];
    wrOk     = we && !exc_valid;
    if (wrOk && wr_addr == 5'd9) begin
      mCountBase = wr_data;
      mTicks     = 0;
    end else begin
      mTicks++;
      if ((mTicks % DIV) == 0 && mCount() == mCompare) mCauseSw[30] = 1'b1;
    end
    if (wrOk && wr_addr == 5'd11) begin
      mCompare     = wr_data;
      mCauseSw[30] = 1'b0;
    end
    if (wrOk && wr_addr == 5'd12) mStatus = mStatusView(wr_data);
    if (wrOk && wr_addr == 5'd13) mCauseSw[9:8] = wr_data[9:8];
    if (wrOk && wr_addr == 5'd14) mEpc = wr_data;
    if (exc_valid) begin
      if (!oldExl) begin
        mEpc         = exc_in_delay ? exc_pc - 32'd4 : exc_pc;
        mCauseSw[31] = exc_in_delay;
      end
      mStatus[1]    = 1'b1;
      mCauseSw[6:2] = exc_code;
      if (exc_bva_valid) mBva = exc_bva;
      mFlush   = 1'b1;
      mFlushPc = VEC;
    end else if (eret) begin
      mStatus[1] = 1'b0;
      mFlush     = 1'b1;
      mFlushPc   = mEpc;
    end else begin
      mFlush = 1'b0;
    end
    mH2      = mH1;
    mH1      = hw_int;
    mIntPend = pend;
  endfunction

  // One clock: check the combinational read mid-cycle, step the model, check registered outputs.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput("rd_data", rd_data, mExpectedRd());
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("flush", {31'd0, flush}, {31'd0, mFlush});
    checkOutput("flush_pc", flush_pc, mFlushPc);
    checkOutput("timer_int_o", {31'd0, timer_int_o}, {31'd0, mCauseSw[30]});
    checkOutput("int_pending", {31'd0, int_pending}, {31'd0, mIntPend});
  endtask

  task automatic setIdle();
    we = 0; wr_addr = 0; wr_data = 0; exc_valid = 0; exc_code = 0; exc_pc = 0;
    exc_in_delay = 0; exc_bva_valid = 0; exc_bva = 0; eret = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    setIdle();
    we = 1; wr_addr = a; wr_data = d;
    applyStimulus();
  endtask

  function automatic logic [4:0] pickAddr();
    case ($urandom_range(0, 7))
      0:       return 5'd8;
      1:       return 5'd9;
      2:       return 5'd11;
      3:       return 5'd12;
      4:       return 5'd13;
      5:       return 5'd14;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    modelReset();
    setIdle();
    hw_int = 0;
    rst = 1;
    rd_addr = 5'd12;
    applyStimulus();
    checkOutput("rst_status", rd_data, 32'h0040_0000);
    rd_addr = 5'd13;
    #1 checkOutput("rst_cause", rd_data, 32'd0);
    rd_addr = 5'd9;
    repeat (2) begin
      applyStimulus();
      checkOutput("rst_count", rd_data, 32'd0);
    end
    rst = 0;

    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    setIdle();
    rd_addr = 5'd9;
    repeat (7) applyStimulus();
    checkOutput("ti_before", {31'd0, timer_int_o}, 32'd0);
    applyStimulus();
    checkOutput("ti_set", {31'd0, timer_int_o}, 32'd1);
    checkOutput("count_at_match", rd_data, 32'd5);
    applyStimulus();
    checkOutput("int_after_ti", {31'd0, int_pending}, 32'd1);
    mtc0(5'd11, 32'd100);
    checkOutput("ti_clear", {31'd0, timer_int_o}, 32'd0);

    setIdle();
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'hBFC0_1004; exc_in_delay = 1;
    exc_bva_valid = 1; exc_bva = 32'h1235;
    applyStimulus();
    checkOutput("exc_flush", {31'd0, flush}, 32'd1);
    checkOutput("exc_flush_pc", flush_pc, 32'hBFC0_0380);
    setIdle();
    rd_addr = 5'd14;
    #1 checkOutput("exc_epc", rd_data, 32'hBFC0_1000);
    rd_addr = 5'd8;
    #1 checkOutput("exc_bva", rd_data, 32'h1235);
    rd_addr = 5'd13;
    #1 checkOutput("exc_cause_bd_code", rd_data & 32'h8000_007C, 32'h8000_0010);
    rd_addr = 5'd12;
    #1 checkOutput("exc_status", rd_data, 32'h0040_8003);
    applyStimulus();
    exc_valid = 1; exc_code = 5'd5; exc_pc = 32'h0000_2000;
    applyStimulus();
    setIdle();
    rd_addr = 5'd14;
    #1 checkOutput("exc2_epc_kept", rd_data, 32'hBFC0_1000);

    setIdle();
    we = 1; wr_addr = 5'd14; wr_data = 32'h8000_0100; eret = 1;
    applyStimulus();
    checkOutput("eret_flush", {31'd0, flush}, 32'd1);
    checkOutput("eret_flush_pc", flush_pc, 32'h8000_0100);
    setIdle();
    rd_addr = 5'd12;
    #1 checkOutput("eret_status", rd_data, 32'h0040_8001);

    we = 1; wr_addr = 5'd12; wr_data = 32'd0; exc_valid = 1; exc_pc = 32'h100;
    applyStimulus();
    setIdle();
    #1 checkOutput("drop_status", rd_data, 32'h0040_8003);

    we = 1; wr_addr = 5'd13; wr_data = 32'hFFFF_FFFF; rd_addr = 5'd13;
    #1 checkOutput("cause_fwd_swip", rd_data & 32'h3FFF_0380, 32'h0000_0300);
    applyStimulus();
    setIdle();
    #1 checkOutput("cause_swip", rd_data & 32'h3FFF_0380, 32'h0000_0300);

    mtc0(5'd12, 32'h0000_0401);
    setIdle();
    hw_int = 6'b000001;
    applyStimulus();
    applyStimulus();
    #1 checkOutput("hw_ip2", rd_data & 32'h0000_0400, 32'h0000_0400);
    applyStimulus();
    checkOutput("hw_int_pending", {31'd0, int_pending}, 32'd1);
    mtc0(5'd12, 32'h0000_0403);
    setIdle();
    applyStimulus();
    checkOutput("exl_masks_int", {31'd0, int_pending}, 32'd0);
    hw_int = 0;

    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFE);
    setIdle();
    repeat (4) applyStimulus();
    checkOutput("ti_wrap", {31'd0, timer_int_o}, 32'd1);

    for (int i = 0; i < 3000; i++) begin
      setIdle();
      rst = ($urandom_range(0, 299) == 0);
      we = 1'($urandom_range(0, 1));
      wr_addr = pickAddr();
      wr_data = $urandom;
      if (wr_addr == 5'd11 && $urandom_range(0, 1) == 1)
        wr_data = mCount() + 32'($urandom_range(1, 6));
      if (wr_addr == 5'd9 && $urandom_range(0, 3) == 0)
        wr_data = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      exc_valid = ($urandom_range(0, 15) == 0);
      exc_code = 5'($urandom_range(0, 31));
      exc_pc = $urandom;
      exc_in_delay = 1'($urandom_range(0, 1));
      exc_bva_valid = 1'($urandom_range(0, 1));
      exc_bva = $urandom;
      eret = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) hw_int = hw_int ^ 6'(1 << $urandom_range(0, 5));
      rd_addr = ($urandom_range(0, 1) == 1) ? wr_addr : pickAddr();
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Parametrised coprocessor-0 for the MIPS core. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and serves mfc0/mtc0 with same-cycle write forwarding. It records exceptions and ERET reported by the writeback stage, and issues a registered one-cycle pipeline flush with a redirect PC. It synchronises up to six hardware interrupt lines, runs a divided Count/Compare timer, and presents a masked interrupt-pending signal to the exception-detection stage.

## Interface
- NUM_HW_INT, 6, hardware interrupt lines, 1..6; line i maps to Cause.IP[2+i]
- COUNT_DIV, 2, clk cycles per Count increment, 1..16
- EXC_VECTOR, 32'hBFC0_0380, general exception redirect address
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rd_addr  in  5  mfc0 register number
- rd_data  out  32  combinational read data (forwarded)
- we  in  1  mtc0 write enable
- wr_addr  in  5  mtc0 register number
- wr_data  in  32  mtc0 data
- exc_valid  in  1  exception committed this cycle
- exc_code  in  5  ExcCode (0 = Int)
- exc_pc  in  32  PC of the faulting instruction
- exc_in_delay  in  1  faulting instruction is in a delay slot
- exc_bva_valid  in  1  load BadVAddr on this exception
- exc_bva  in  32  bad virtual address
- eret  in  1  ERET committed this cycle
- hw_int  in  NUM_HW_INT  asynchronous-level interrupt requests
- int_pending  out  1  interrupt may be taken; registered
- timer_int_o  out  1  Cause.TI; registered
- flush  out  1  one-cycle pipeline flush; registered
- flush_pc  out  32  redirect target, valid when flush=1

## Operation
- Register map: 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Other addresses read 0 and ignore writes.
- Status writable bits: IM[15:8], EXL[1], IE[0]. BEV[22] reads 1. All other bits read 0.
- Cause fields:
  - BD[31] and TI[30] are read-only.
  - IP[7:2] are hardware-driven.
  - IP[1:0] are software-writable.
  - ExcCode[6:2] is read-only.
  - All other bits read 0.
- hw_int is double-flop synchronised. IP[2+i] = synced hw_int[i]. IP[7] = TI OR (NUM_HW_INT==6 ? hw_int[5] : 0). Unused IP bits read 0.
- int_pending = |(IP & IM) & IE & ~EXL, registered.
- Timer:
  - A divider counts 0..COUNT_DIV-1. Count increments when the divider wraps.
  - When an increment makes Count equal Compare, TI is set.
  - A Compare write clears TI.
  - A Count write loads Count and zeroes the divider.
  - Count wraps 32'hFFFF_FFFF -> 0 with no flag.
- Exception (exc_valid=1):
  - If EXL=0: EPC = exc_in_delay ? exc_pc-4 : exc_pc, and BD = exc_in_delay.
  - If EXL=1: EPC and BD are unchanged.
  - EXL is set to 1 and ExcCode = exc_code.
  - BadVAddr = exc_bva only if exc_bva_valid.
  - flush_pc = EXC_VECTOR.
- ERET (eret=1, exc_valid=0): EXL is cleared and flush_pc = EPC. If an mtc0 EPC occurs in the same cycle, the forwarded wr_data is used.
- Priority: exc_valid > eret > mtc0. An mtc0 in the same cycle as exc_valid is dropped. An mtc0 in the same cycle as eret is performed.
- Read forwarding: if we && wr_addr==rd_addr, rd_data returns the post-write value with read-only bits and masking applied. Otherwise rd_data returns the register value.

## Timing
- Reset values: Status 0x0040_0000. All other registers 0, including the divider and synchronisers. rd_data reflects these values. All outputs are 0: int_pending, timer_int_o, flush and flush_pc.
- Register updates take effect at the next clk edge. rd_data has zero latency.
- flush rises the cycle after exc_valid or eret and lasts exactly one cycle, unless a new event follows back-to-back.
- flush_pc holds its last value while flush=0.
- hw_int to IP latency is 2 cycles, and to int_pending 3 cycles.
- TI is set on the edge where Count becomes equal to Compare. timer_int_o follows on that same edge.
- rst asserted mid-operation: every state returns to reset values on the next edge. A pending flush is cancelled.
- Compare = 0 is treated as a real match value: TI sets when Count wraps to 0.

## Test plan
- Reset, then read addresses 12 and 13 -> 0x0040_0000 and 0. Read address 9 stays 0 only while rst is held.
- COUNT_DIV=2, write Compare=5 at Count=0 -> Count reaches 5 after 10 cycles. TI=1 and timer_int_o=1 on that edge. With IM[7]=1, IE=1 and EXL=0, int_pending=1 one cycle later. Writing Compare clears TI.
- exc_valid with exc_code=4, exc_pc=0xBFC0_1004, exc_in_delay=1, exc_bva_valid=1, exc_bva=0x1235 -> next cycle: flush=1, flush_pc=0xBFC0_0380, EPC=0xBFC0_1000, BD=1, ExcCode=4, BadVAddr=0x1235, EXL=1. A second exception while EXL=1 leaves EPC unchanged.
- mtc0 EPC=0x8000_0100 together with eret -> flush next cycle with flush_pc=0x8000_0100 and EXL=0.
- mtc0 Status while exc_valid is asserted in the same cycle -> the write is dropped. mtc0 to Cause with 0xFFFF_FFFF -> Cause reads only IP[1:0]=11 plus the hardware-driven bits. A forwarded read shows the same masked value in the same cycle.
- hw_int[0] pulse -> IP[2] set 2 cycles later. With IM[2]=1 and IE=1, int_pending is raised on cycle 3. Setting EXL=1 drops int_pending the next cycle.
